// File: rtl/cb_dff_syncwrst.sv
// Enabled D flip-flop register, parameterised width, asynchronous active-low reset.
// Optional complemented output Qn is built when CB_DFF_SYNCWRST_QN_EN is defined.
module cb_dff_syncwrst #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic [WIDTH-1:0] D,
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] Q
`ifdef CB_DFF_SYNCWRST_QN_EN
    ,
    output logic [WIDTH-1:0] Qn
`endif
);

    logic [WIDTH-1:0] r_q;

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("cb_dff_syncwrst: WIDTH must be in 1..64");
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= RESET_VAL;
        end else if (en) begin
            r_q <= D;
        end
    end

    assign Q = r_q;

`ifdef CB_DFF_SYNCWRST_QN_EN
    // Complement taken from the flops, never from D, so Qn is glitch-free w.r.t. inputs.
    assign Qn = ~r_q;
`endif

endmodule

// File: tb/tb_cb_dff_syncwrst.sv
// Scoreboard bench for cb_dff_syncwrst: 1-bit default instance and 8-bit A5-reset instance.
// Define CB_DFF_SYNCWRST_QN_EN at compile time to also check Qn.
`timescale 1ns/1ps
module tb_cb_dff_syncwrst;

    typedef struct packed {
        logic       q1;
        logic [7:0] q8;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic       D1  = 1'b0;
    logic [7:0] D8  = 8'h00;
    logic       Q1;
    logic [7:0] Q8;
`ifdef CB_DFF_SYNCWRST_QN_EN
    logic       Qn1;
    logic [7:0] Qn8;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];

    // Reference state: what each register should hold right now.
    logic       m1;
    logic [7:0] m8;

    always #10 clk = ~clk;

    cb_dff_syncwrst u_dut1 (
        .D   (D1),
        .clk (clk),
        .rst (rst),
        .en  (en),
        .Q   (Q1)
`ifdef CB_DFF_SYNCWRST_QN_EN
        ,
        .Qn  (Qn1)
`endif
    );

    cb_dff_syncwrst #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
        .D   (D8),
        .clk (clk),
        .rst (rst),
        .en  (en),
        .Q   (Q8)
`ifdef CB_DFF_SYNCWRST_QN_EN
        ,
        .Qn  (Qn8)
`endif
    );

    // Model: reset wins immediately; otherwise an enabled edge loads D, else keep.
    always @(posedge clk or negedge rst) begin
        exp_t e;
        if (!rst) begin
            m1 = 1'b0;
            m8 = 8'hA5;
        end else if (en) begin
            m1 = D1;
            m8 = D8;
        end
        e.q1 = m1;
        e.q8 = m8;
        sb.push_back(e);
    end

    // Monitor: each clock edge or reset assertion produces one observation 1 ns later.
    always @(posedge clk or negedge rst) begin
        exp_t e;
        #1;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: actual empty queue, required an entry at %0t", $time);
        end else begin
            e = sb.pop_front();
            if (Q1 !== e.q1) begin
                n_fail++;
                $display("FAIL q1 @%0t: actual %b required %b", $time, Q1, e.q1);
            end
            n_tests++;
            if (Q8 !== e.q8) begin
                n_fail++;
                $display("FAIL q8 @%0t: actual %h required %h", $time, Q8, e.q8);
            end
`ifdef CB_DFF_SYNCWRST_QN_EN
            n_tests++;
            if (Qn1 !== ~e.q1) begin
                n_fail++;
                $display("FAIL qn1 @%0t: actual %b required %b", $time, Qn1, ~e.q1);
            end
            n_tests++;
            if (Qn8 !== ~e.q8) begin
                n_fail++;
                $display("FAIL qn8 @%0t: actual %h required %h", $time, Qn8, ~e.q8);
            end
`endif
        end
    end

    // Wait for the next rising edge, then move dly ns past it.
    task automatic after_edge(input int dly);
        @(posedge clk);
        #(dly);
    endtask

    initial begin
        // Reset held with enable on and D toggling: outputs stay at reset value.
        for (int i = 0; i < 5; i++) begin
            after_edge(3);
            D1 = ~D1;
            D8 = ~D8;
        end
        // Release 3 ns after an edge with D loaded: capture on the following edge.
        D1 = 1'b1;
        D8 = 8'h3C;
        rst = 1'b1;
        after_edge(3);
        // Mid-cycle reset assertion: checked 1 ns later, no clock needed.
        after_edge(5);
        rst = 1'b0;
        after_edge(3);
        after_edge(3);
        rst = 1'b1;
        // Capture 0 then 1, held across edges.
        D1 = 1'b0;
        D8 = 8'h00;
        after_edge(3);
        D1 = 1'b1;
        D8 = 8'hFF;
        repeat (3) after_edge(3);
        D1 = 1'b0;
        D8 = 8'h81;
        after_edge(3);
        // Hold: enable low, D changed, outputs must not follow.
        en = 1'b0;
        D1 = 1'b1;
        D8 = 8'h5E;
        repeat (3) after_edge(3);
        en = 1'b1;
        after_edge(3);
        // Randomised traffic with occasional mid-cycle reset pulses.
        for (int i = 0; i < 300; i++) begin
            after_edge(3);
            rst = 1'b1;
            D1  = 1'($urandom);
            D8  = 8'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                #2;
                rst = 1'b0;
            end
        end
        after_edge(3);
        rst = 1'b1;
        repeat (3) after_edge(3);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: actual %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
